core_sequencer: RTL
===================

Name: core_sequencer

Overview:
- Multi-cycle control sequencer for the 32-bit RISC-V core datapath (pc_mux, inst_mem, reg_file, alu, data_mem).
- Replaces the free-running `step` toggle.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB/PCUPD, gating the PC, register-file and data-memory write/read enables.
- Supports run, single-step and halt, handles a data-memory ready handshake, and traps illegal opcodes and memory timeouts.

Parameters:
- CPU_BITS, 32, datapath width; sets the width of cycle_count and instr_count.
- TIMEOUT_W, 4, width of the memory-wait counter.
- MEM_TIMEOUT, 15, maximum cycles in MEM without mem_ready before trap.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk externally.
- run  in  1  level; 1 = execute continuously.
- step_req  in  1  one-cycle pulse; execute exactly one instruction from IDLE.
- halt_req  in  1  level; stop at next instruction boundary.
- resume  in  1  one-cycle pulse; leave HALT.
- opcode  in  7  instruction[6:0] from instruction register.
- branch_taken  in  1  taken indication (ALU result zero AND branch).
- mem_ready  in  1  data memory has completed the read or write.
- ir_we  out  1  latch instruction.
- reg_we  out  1  register-file write enable.
- dmem_rd  out  1  data-memory read request.
- dmem_wr  out  1  data-memory write request.
- pc_we  out  1  PC update enable.
- pc_src  out  1  1 = jump address, 0 = PC+1.
- busy  out  1  not in IDLE/HALT.
- halted  out  1  in HALT.
- illegal_op  out  1  sticky trap flag.
- mem_err  out  1  sticky timeout flag.
- state  out  3  current state encoding.
- instr_count  out  CPU_BITS  retired instructions.
- cycle_count  out  CPU_BITS  cycles while busy.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, counters 0, flags cleared, single-step latch cleared.
- Outputs are Moore decodes of the state register. There is no combinational path from inputs to outputs, except pc_src = branch_taken in PCUPD for branch opcodes; pc_src is 0 otherwise.
- Opcode classes: 0x33 R, 0x03 LOAD, 0x23 STORE, 0x63 BRANCH. Every other opcode is illegal.
- IDLE:
  - halt_req=1 → HALT; this has priority.
  - run=1 → FETCH.
  - step_req=1 → FETCH, and the single-step latch is set.
  - Otherwise stay.
- FETCH: ir_we=1 → DECODE.
- DECODE:
  - Legal opcode → EXEC.
  - Illegal opcode → HALT; illegal_op set; instr_count not incremented.
- EXEC (ALU settles):
  - R → WB.
  - LOAD/STORE → MEM; wait counter cleared.
  - BRANCH → PCUPD.
- MEM:
  - dmem_rd (LOAD) or dmem_wr (STORE) is held continuously until mem_ready=1.
  - On mem_ready: LOAD → WB; STORE → PCUPD.
  - The wait counter increments each cycle without mem_ready. Reaching MEM_TIMEOUT → HALT with mem_err set, and dmem_* deasserted on entry to HALT.
  - mem_ready=1 in the first MEM cycle gives zero wait.
- WB: reg_we=1 → PCUPD.
- PCUPD:
  - pc_we=1 and instr_count+1.
  - Then, in priority order: halt_req → HALT; single-step latch → IDLE (latch cleared); run=0 → IDLE; else → FETCH.
- HALT: resume=1 → IDLE. illegal_op and mem_err are cleared on resume.
- Latency with zero memory wait:
  - R: 5 cycles.
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
  - BRANCH: 4 cycles.
- Counter rules:
  - cycle_count increments each cycle busy=1.
  - Both counters wrap modulo 2^CPU_BITS.
- Ignored inputs:
  - step_req is ignored outside IDLE.
  - halt_req mid-instruction takes effect only at PCUPD; the instruction completes.
  - run dropping mid-instruction completes the current instruction.
- Reset mid-instruction aborts immediately. No partial write enable survives, because outputs go to 0 asynchronously.

Decomposition:
- Shared package core_seq_pkg holds:
  - State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCUPD=6, HALT=7.
  - Opcode constants: 0x33, 0x03, 0x23, 0x63.
  - Default MEM_TIMEOUT.
- One sub-module, seq_wait_timer: loadable up-counter with terminal flag, used for MEM timeout.

Test Plan:
- Reset low mid-MEM with dmem_wr=1 → dmem_wr=0, state=0, counters 0 immediately, without waiting for a clock edge.
- run=1, opcode=0x33 → state sequence 1,2,3,5,6 repeating; ir_we, reg_we and pc_we each pulse once per 5 cycles; instr_count=2 after 10 cycles.
- step_req pulse, opcode=0x03, mem_ready delayed 3 cycles → dmem_rd high 4 cycles, reg_we once, pc_we once, return to IDLE; instr_count=1; cycle_count=9.
- opcode=0x63, branch_taken=1 → pc_we=1 with pc_src=1 in cycle 4; with branch_taken=0, pc_src=0.
- opcode=0x13 (illegal) → HALT after DECODE, illegal_op=1, halted=1, instr_count unchanged; resume pulse → IDLE, illegal_op=0.
- STORE, mem_ready held 0 → after 15 MEM cycles state=7, mem_err=1, dmem_wr=0.
- halt_req asserted during EXEC of R-type → WB and PCUPD complete, instr_count+1, then HALT.

Source files
------------

// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encodings, opcode classes and defaults for core_sequencer
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {C_R, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL} op_class_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam int MEM_TIMEOUT_DEF = 15;

  function automatic op_class_t op_class(input logic [6:0] op);
    return op == OP_R      ? C_R      :
           op == OP_LOAD   ? C_LOAD   :
           op == OP_STORE  ? C_STORE  :
           op == OP_BRANCH ? C_BRANCH : C_ILLEGAL;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: clearable up-counter flagging the last allowed wait cycle
//   clk, reset (async active-low), i_load (clear to 0), i_inc (count up),
//   o_last (count has reached LAST-1, so one more miss reaches LAST)
module seq_wait_timer #(
  parameter int W    = 4,
  parameter int LAST = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_inc,
  output logic o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset)
    if (!reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= '0;
    else if (i_inc)
      r_cnt <= r_cnt + W'(1);

  assign o_last = r_cnt == W'(LAST - 1);

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB/PCUPD control for the RISC-V datapath
//   inputs : clk, reset (async active-low), run, step_req, halt_req, resume,
//            opcode[6:0], branch_taken, mem_ready
//   outputs: ir_we, reg_we, dmem_rd, dmem_wr, pc_we, pc_src, busy, halted,
//            illegal_op, mem_err, state[2:0], instr_count, cycle_count
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int CPU_BITS    = 32,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step_req,
  input  logic                halt_req,
  input  logic                resume,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                reg_we,
  output logic                dmem_rd,
  output logic                dmem_wr,
  output logic                pc_we,
  output logic                pc_src,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [2:0]          state,
  output logic [CPU_BITS-1:0] instr_count,
  output logic [CPU_BITS-1:0] cycle_count
);

  state_t              r_state, w_next;
  op_class_t           r_cls;
  op_class_t           w_cls;
  logic                r_step, r_illegal, r_mem_err, w_last;
  logic [CPU_BITS-1:0] r_instr, r_cycle;

  assign w_cls = op_class(opcode);

  seq_wait_timer #(.W(TIMEOUT_W), .LAST(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == S_EXEC),
    .i_inc  (r_state == S_MEM && !mem_ready),
    .o_last (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = halt_req ? S_HALT : (run || step_req) ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_cls == C_ILLEGAL ? S_HALT : S_EXEC;
      S_EXEC:   w_next = r_cls == C_R ? S_WB : r_cls == C_BRANCH ? S_PCUPD : S_MEM;
      S_MEM:    w_next = mem_ready ? (r_cls == C_LOAD ? S_WB : S_PCUPD) : w_last ? S_HALT : S_MEM;
      S_WB:     w_next = S_PCUPD;
      S_PCUPD:  w_next = halt_req ? S_HALT : (r_step || !run) ? S_IDLE : S_FETCH;
      S_HALT:   w_next = resume ? S_IDLE : S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // The opcode class is captured in DECODE so later states (and pc_src) do not
  // depend on the opcode input; the step latch only survives one instruction.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cls     <= C_R;
      r_step    <= 1'b0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
      r_instr   <= '0;
      r_cycle   <= '0;
    end else begin
      r_state   <= w_next;
      r_cls     <= r_state == S_DECODE ? w_cls : r_cls;
      r_step    <= r_state == S_IDLE ? (w_next == S_FETCH && !run) :
                   (r_state == S_PCUPD || w_next == S_HALT) ? 1'b0 : r_step;
      r_illegal <= (r_state == S_DECODE && w_next == S_HALT) ? 1'b1 :
                   (r_state == S_HALT && resume) ? 1'b0 : r_illegal;
      r_mem_err <= (r_state == S_MEM && w_next == S_HALT) ? 1'b1 :
                   (r_state == S_HALT && resume) ? 1'b0 : r_mem_err;
      r_instr   <= r_state == S_PCUPD ? r_instr + CPU_BITS'(1) : r_instr;
      r_cycle   <= busy ? r_cycle + CPU_BITS'(1) : r_cycle;
    end

  assign ir_we       = r_state == S_FETCH;
  assign reg_we      = r_state == S_WB;
  assign dmem_rd     = r_state == S_MEM && r_cls == C_LOAD;
  assign dmem_wr     = r_state == S_MEM && r_cls == C_STORE;
  assign pc_we       = r_state == S_PCUPD;
  assign pc_src      = r_state == S_PCUPD && r_cls == C_BRANCH && branch_taken;
  assign busy        = r_state != S_IDLE && r_state != S_HALT;
  assign halted      = r_state == S_HALT;
  assign illegal_op  = r_illegal;
  assign mem_err     = r_mem_err;
  assign state       = r_state;
  assign instr_count = r_instr;
  assign cycle_count = r_cycle;

endmodule
